i2c_slave_regs: RTL and testbench

I2C target (slave) that answers the single-byte register transactions our I2C master issues, bridging them onto a simple 8-bit register-file port. It sits on the device side of the bus: it decodes START, repeated START and STOP, matches a fixed 7-bit address, takes a register pointer byte, then writes incoming data bytes or returns register contents. Open-drain SDA only; SCL is input-only, with no clock stretching.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_sync_edge.sv | 45 ++++
 rtl/i2c_slave_regs.sv | 240 ++++++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C register target
package i2c_pkg;

    localparam int   SYNC_STAGES = 2;
    localparam logic I2C_WRITE   = 1'b0;
    localparam logic I2C_READ    = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } i2c_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - 2-FF synchronizer with registered level, rise and fall
module i2c_sync_edge
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Shift the pin through the synchronizer; level and edges are aligned one stage later
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        level_d = sync_q[SYNC_STAGES-1];
        rise_d  = sync_q[SYNC_STAGES-1] & ~level_q;
        fall_d  = ~sync_q[SYNC_STAGES-1] & level_q;
    end

    // Registers reset to the idle bus level (high) so reset never fabricates an edge from idle
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= {SYNC_STAGES{1'b1}};
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C target bridging single-byte transactions to a register port
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h1A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_sclk,
    inout  wire        i2c_sdat,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_sync_edge u_scl_sync (
        .clk   (clk),
        .reset (reset),
        .din   (i2c_sclk),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk   (clk),
        .reset (reset),
        .din   (i2c_sdat),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    i2c_state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [6:0] tx_q, tx_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rw_q, rw_d;
    logic       mack_q, mack_d;
    logic       load_q, load_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       reg_we_q, reg_we_d;
    logic       reg_re_q, reg_re_d;
    logic       busy_q, busy_d;
    logic [7:0] rx_byte;

    // Next-state logic: bus conditions override everything, otherwise advance per SCL edge
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        sda_oe_d    = sda_oe_q;
        rw_d        = rw_q;
        mack_d      = mack_q;
        load_d      = reg_re_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        busy_d      = busy_q;
        rx_byte     = {shift_q, sda_lvl};

        // Pointer advances the cycle after each write strobe
        if (reg_we_q) begin
            reg_addr_d = reg_addr_q + 8'd1;
        end

        // Register file answers one cycle after reg_re; its MSB goes straight onto SDA
        if (load_q) begin
            tx_d     = reg_rdata[6:0];
            sda_oe_d = ~reg_rdata[7];
        end

        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            mack_d    = 1'b0;
            load_d    = 1'b0;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            mack_d    = 1'b0;
            load_d    = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (shift_q == SLAVE_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = sda_lvl;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                ST_PTR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d  = 4'd0;
                            reg_addr_d = rx_byte;
                            state_d    = ST_PTR_ACK;
                        end
                    end
                end
                ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d   = 4'd0;
                            reg_wdata_d = rx_byte;
                            reg_we_d    = 1'b1;
                            state_d     = ST_WDATA_ACK;
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    // First falling edge starts the ACK, the second one ends it
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            if (state_q == ST_ADDR_ACK && rw_q == I2C_READ) begin
                                state_d  = ST_RDATA;
                                reg_re_d = 1'b1;
                            end else if (state_q == ST_ADDR_ACK) begin
                                state_d = ST_PTR;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            bit_cnt_d = 4'd0;
                            sda_oe_d  = 1'b0;
                            state_d   = ST_RDATA_ACK;
                        end else begin
                            sda_oe_d = ~tx_q[6];
                            tx_d     = {tx_q[5:0], 1'b1};
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    // Decide on the master's ACK at the rise, but only start driving after the fall
                    if (scl_rise) begin
                        if (!sda_lvl) begin
                            mack_d     = 1'b1;
                            reg_addr_d = reg_addr_q + 8'd1;
                        end else begin
                            state_d = ST_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end else if (scl_fall && mack_q) begin
                        mack_d    = 1'b0;
                        bit_cnt_d = 4'd0;
                        reg_re_d  = 1'b1;
                        state_d   = ST_RDATA;
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; reset releases SDA and suppresses strobes on the same edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 7'd0;
            tx_q        <= 7'h7F;
            sda_oe_q    <= 1'b0;
            rw_q        <= I2C_WRITE;
            mack_q      <= 1'b0;
            load_q      <= 1'b0;
            reg_addr_q  <= 8'd0;
            reg_wdata_q <= 8'd0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            sda_oe_q    <= sda_oe_d;
            rw_q        <= rw_d;
            mack_q      <= mack_d;
            load_q      <= load_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            busy_q      <= busy_d;
        end
    end

    assign i2c_sdat  = sda_oe_q ? 1'b0 : 1'bz;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb/tb_i2c_slave_regs.sv - directed bench for the I2C register target
module tb_i2c_slave_regs;
    import i2c_pkg::*;

    localparam int Q = 50;

    logic       clk;
    logic       reset;
    logic       scl;
    logic       m_oe;
    wire        sda;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    logic [7:0] mem [256];
    logic [7:0] we_addr_log [$];
    logic [7:0] we_data_log [$];
    logic [7:0] re_addr_log [$];
    int         drive_cnt;
    int         checks;
    int         errors;

    pullup (sda);
    assign sda = m_oe ? 1'b0 : 1'bz;

    i2c_slave_regs #(.SLAVE_ADDR(7'h1A)) dut (
        .clk       (clk),
        .reset     (reset),
        .i2c_sclk  (scl),
        .i2c_sdat  (sda),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (reg_re) reg_rdata <= mem[reg_addr];
    end

    always @(negedge clk) begin
        if (reg_we) begin
            we_addr_log.push_back(reg_addr);
            we_data_log.push_back(reg_wdata);
        end
        if (reg_re) re_addr_log.push_back(reg_addr);
        if (!m_oe && sda === 1'b0) drive_cnt++;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        m_oe = ~b;
        #Q scl = 1'b1;
        #Q s = sda;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_start();
        m_oe = 1'b0;
        #Q scl = 1'b1;
        #Q m_oe = 1'b1;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop();
        m_oe = 1'b1;
        #Q scl = 1'b1;
        #Q m_oe = 1'b0;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d, output logic ack_line);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(nack, ack_line);
    endtask

    typedef struct {
        logic [7:0] ptr;
        logic [7:0] data;
        logic [7:0] exp_we_addr;
        logic [7:0] exp_wdata;
        logic [7:0] exp_addr_after;
    } wvec_t;

    initial begin
        wvec_t      wv [3];
        logic       a0, a1, a2, a3, a4;
        logic [7:0] rd0, rd1;
        int         wb, rb, db;

        wv[0] = '{8'h05, 8'h3C, 8'h05, 8'h3C, 8'h06};
        wv[1] = '{8'hFF, 8'h80, 8'hFF, 8'h80, 8'h00};
        wv[2] = '{8'h7E, 8'h01, 8'h7E, 8'h01, 8'h7F};

        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        mem[8'h05] = 8'hA5;
        mem[8'h06] = 8'h5A;
        mem[8'h10] = 8'h00;

        checks = 0; errors = 0; drive_cnt = 0;
        reg_rdata = 8'h00;
        scl = 1'b1; m_oe = 1'b0; reset = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_reg_addr", reg_addr, 8'h00);
        check("reset_reg_wdata", reg_wdata, 8'h00);
        check("reset_strobes", {6'd0, reg_we, reg_re}, 8'h00);
        check("reset_busy", {7'd0, busy}, 8'h00);
        check("reset_sda", {7'd0, sda}, 8'h01);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Table-driven single-byte writes
        for (int i = 0; i < 3; i++) begin
            wb = we_addr_log.size();
            i2c_start();
            write_byte(8'h34, a0);
            write_byte(wv[i].ptr, a1);
            write_byte(wv[i].data, a2);
            i2c_stop();
            #(4*Q);
            check($sformatf("w%0d_acks", i), {5'd0, a0, a1, a2}, 8'h00);
            check($sformatf("w%0d_we_count", i), 8'(we_addr_log.size() - wb), 8'd1);
            if (we_addr_log.size() > wb) begin
                check($sformatf("w%0d_we_addr", i), we_addr_log[wb], wv[i].exp_we_addr);
                check($sformatf("w%0d_wdata", i), we_data_log[wb], wv[i].exp_wdata);
            end
            check($sformatf("w%0d_addr_after", i), reg_addr, wv[i].exp_addr_after);
            check($sformatf("w%0d_busy_after", i), {7'd0, busy}, 8'h00);
        end

        // Pointer write, repeated START, two-byte read (ACK then NACK)
        rb = re_addr_log.size();
        i2c_start();
        write_byte(8'h34, a0);
        write_byte(8'h05, a1);
        i2c_start();
        write_byte(8'h35, a2);
        read_byte(1'b0, rd0, a3);
        read_byte(1'b1, rd1, a4);
        i2c_stop();
        #(4*Q);
        check("rd_acks", {5'd0, a0, a1, a2}, 8'h00);
        check("rd_re_count", 8'(re_addr_log.size() - rb), 8'd2);
        if (re_addr_log.size() >= rb + 2) begin
            check("rd_re_addr0", re_addr_log[rb], 8'h05);
            check("rd_re_addr1", re_addr_log[rb+1], 8'h06);
        end
        check("rd_data0", rd0, 8'hA5);
        check("rd_data1", rd1, 8'h5A);
        check("rd_nack_released", {7'd0, a4}, 8'h01);
        check("rd_addr_after", reg_addr, 8'h06);
        check("rd_busy_after", {7'd0, busy}, 8'h00);

        // Address mismatch: target must stay silent
        wb = we_addr_log.size(); rb = re_addr_log.size(); db = drive_cnt;
        i2c_start();
        write_byte(8'h50, a0);
        check("mm_busy", {7'd0, busy}, 8'h00);
        write_byte(8'h05, a1);
        i2c_stop();
        #(4*Q);
        check("mm_nack", {6'd0, a0, a1}, 8'h03);
        check("mm_strobes", 8'((we_addr_log.size() - wb) + (re_addr_log.size() - rb)), 8'd0);
        check("mm_never_driven", 8'(drive_cnt - db), 8'd0);

        // Burst write with pointer wrap
        wb = we_addr_log.size();
        i2c_start();
        write_byte(8'h34, a0);
        check("bw_busy", {7'd0, busy}, 8'h01);
        write_byte(8'hFE, a1);
        write_byte(8'h11, a2);
        write_byte(8'h22, a3);
        write_byte(8'h33, a4);
        i2c_stop();
        #(4*Q);
        check("bw_acks", {3'd0, a0, a1, a2, a3, a4}, 8'h00);
        check("bw_we_count", 8'(we_addr_log.size() - wb), 8'd3);
        if (we_addr_log.size() >= wb + 3) begin
            check("bw_addr0", we_addr_log[wb], 8'hFE);
            check("bw_addr1", we_addr_log[wb+1], 8'hFF);
            check("bw_addr2", we_addr_log[wb+2], 8'h00);
            check("bw_data2", we_data_log[wb+2], 8'h33);
        end
        check("bw_addr_after", reg_addr, 8'h01);

        // Reset while the target is driving read bit 3 low
        i2c_start();
        write_byte(8'h34, a0);
        write_byte(8'h10, a1);
        i2c_start();
        write_byte(8'h35, a2);
        for (int i = 0; i < 3; i++) bit_xfer(1'b1, a3);
        check("rst_driving_low", {7'd0, sda}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_sda_released", {7'd0, sda}, 8'h01);
        check("rst_reg_addr", reg_addr, 8'h00);
        check("rst_reg_wdata", reg_wdata, 8'h00);
        check("rst_strobes_busy", {5'd0, reg_we, reg_re, busy}, 8'h00);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        i2c_stop();
        #(4*Q);

        // STOP four bits into a data byte
        wb = we_addr_log.size();
        i2c_start();
        write_byte(8'h34, a0);
        write_byte(8'h20, a1);
        bit_xfer(1'b1, a2);
        bit_xfer(1'b0, a2);
        bit_xfer(1'b1, a2);
        bit_xfer(1'b0, a2);
        i2c_stop();
        #(4*Q);
        check("sp_acks", {6'd0, a0, a1}, 8'h00);
        check("sp_state_idle", {4'd0, dut.state_q}, {4'd0, ST_IDLE});
        check("sp_no_we", 8'(we_addr_log.size() - wb), 8'd0);
        check("sp_ptr_kept", reg_addr, 8'h20);
        check("sp_busy", {7'd0, busy}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
